// File: rtl/tmds_rx_if.sv
// tmds_rx_if: deserializer word in, decoded TMDS symbol and alignment status out
interface tmds_rx_if;
    logic [9:0] tmds_din;
    logic       de;
    logic [1:0] c;
    logic [7:0] data;
    logic       locked;
    logic [3:0] bit_offset;
    modport master (output tmds_din, input de, c, data, locked, bit_offset);
    modport slave  (input tmds_din, output de, c, data, locked, bit_offset);
endinterface

// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: aligns a raw 10-bit TMDS word stream on control tokens and decodes symbols
module tmds_rx_decoder #(
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOCK_CNT       = 16,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input logic     sys_clk,
    input logic     sys_rst,
    tmds_rx_if.slave rx
);
    localparam logic [15:0] S_LAST = 16'(SEARCH_TIMEOUT - 1);
    localparam logic [15:0] V_LAST = 16'(LOCK_CNT - 1);
    localparam logic [15:0] L_LAST = 16'(LOSS_TIMEOUT - 1);
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
    state_t      state, state_n;
    logic [9:0]  d0, d1, sym;
    logic [19:0] win;
    logic [15:0] cnt, cnt_n;
    logic [3:0]  off, off_n, off_inc;
    logic [7:0]  qp, dec;
    logic [1:0]  tok_c;
    logic        is_tok, lock_n;
    // d1 holds the older word, so its bits come first in the serial stream
    assign win = {d0, d1};
    assign sym = win[{1'b0, off} +: 10];
    assign off_inc = off == 4'd9 ? 4'd0 : off + 4'd1;
    assign rx.bit_offset = off;
    always_comb begin
        is_tok = sym inside {10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
        tok_c = sym == 10'b0010101011 ? 2'd1 :
                sym == 10'b0101010100 ? 2'd2 :
                sym == 10'b1010101011 ? 2'd3 : 2'd0;
        qp = sym[9] ? ~sym[7:0] : sym[7:0];
        dec = {sym[8] ? qp[7:1] ^ qp[6:0] : ~(qp[7:1] ^ qp[6:0]), qp[0]};
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt + 16'd1;
        off_n = off;
        case (state)
            SEARCH: begin
                if (is_tok) begin
                    state_n = VERIFY;
                    cnt_n = 16'd1;
                end else if (cnt == S_LAST) begin
                    off_n = off_inc;
                    cnt_n = 16'd0;
                end
            end
            VERIFY: begin
                if (!is_tok) begin
                    state_n = SEARCH;
                    cnt_n = 16'd0;
                end else if (cnt == V_LAST) begin
                    state_n = LOCKED;
                    cnt_n = 16'd0;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    cnt_n = 16'd0;
                end else if (cnt == L_LAST) begin
                    state_n = SEARCH;
                    off_n = off_inc;
                    cnt_n = 16'd0;
                end
            end
            default: begin
                state_n = SEARCH;
                cnt_n = 16'd0;
            end
        endcase
        lock_n = state_n == LOCKED;
    end
    // outputs follow the lock state being entered, so decode starts with the locking token
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            d0 <= '0;
            d1 <= '0;
            state <= SEARCH;
            cnt <= '0;
            off <= '0;
            rx.locked <= 1'b0;
            rx.de <= 1'b0;
            rx.c <= 2'd0;
            rx.data <= 8'd0;
        end else begin
            d0 <= rx.tmds_din;
            d1 <= d0;
            state <= state_n;
            cnt <= cnt_n;
            off <= off_n;
            rx.locked <= lock_n;
            rx.de <= lock_n && !is_tok;
            rx.c <= !lock_n ? 2'd0 : is_tok ? tok_c : rx.c;
            rx.data <= lock_n && !is_tok ? dec : 8'd0;
        end
    end
endmodule
